// File: rtl/operand_assembler_pkg.sv
// Shared widths and state encoding for the operand assembler.
package operand_assembler_pkg;
  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned SLOTS     = 3;
  localparam int unsigned OPERAND_W = NIBBLE_W * SLOTS;

  typedef enum logic {
    FILL,
    FULL
  } state_t;
endpackage

// File: rtl/operand_assembler_onehot_chk.sv
// Classifies a 3-bit slot select: valid when exactly one bit is set, plus its index.
module onehot_chk (
  input  logic [2:0] sel,
  output logic       valid,
  output logic [1:0] idx
);
  always_comb begin
    valid = 1'b1;
    idx   = 2'd0;
    unique case (sel)
      3'b001:  idx = 2'd0;
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/operand_assembler.sv
// Collects three nibbles in any slot order into a 12-bit operand and holds it until RDY.
module operand_assembler
  import operand_assembler_pkg::*;
(
  input  logic                 CLK1,
  input  logic                 RST_C,
  input  logic                 LDD,
  input  logic [SLOTS-1:0]     SEL,
  input  logic [NIBBLE_W-1:0]  D,
  input  logic                 RDY,
  output logic [OPERAND_W-1:0] Q,
  output logic                 VLD,
  output logic [SLOTS-1:0]     MASK,
  output logic                 ERR,
  output logic                 OVF
);
  state_t               state;
  logic [OPERAND_W-1:0] asmBuf;
  logic [OPERAND_W-1:0] asmNext;
  logic [SLOTS-1:0]     maskNext;
  logic                 selOk;
  logic [1:0]           selIdx;

  onehot_chk uSelChk (
    .sel   (SEL),
    .valid (selOk),
    .idx   (selIdx)
  );

  // Buffer with the incoming nibble merged in, so completion can capture it in the same edge.
  always_comb begin
    asmNext = asmBuf;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (selIdx == 2'(k)) asmNext[k*NIBBLE_W +: NIBBLE_W] = D;
    end
    maskNext = MASK | SEL;
  end

  always_ff @(posedge CLK1) begin
    if (RST_C) begin
      state  <= FILL;
      asmBuf <= '0;
      Q      <= '0;
      VLD    <= 1'b0;
      MASK   <= '0;
      ERR    <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (LDD) begin
            if (selOk) begin
              asmBuf <= asmNext;
              if (maskNext == '1) begin
                Q     <= asmNext;
                VLD   <= 1'b1;
                MASK  <= '0;
                state <= FULL;
              end else begin
                MASK <= maskNext;
              end
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        FULL: begin
          if (RDY) begin
            VLD   <= 1'b0;
            state <= FILL;
            // MASK is empty while FULL, so a concurrent load starts the new frame.
            if (LDD) begin
              if (selOk) begin
                asmBuf <= asmNext;
                MASK   <= SEL;
              end else begin
                ERR <= 1'b1;
              end
            end
          end else if (LDD) begin
            OVF <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: doc/operand_assembler.md
OPERAND_ASSEMBLER -- requirements
Module: operand_assembler

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset, with ports named CLK1 and RST_C.
REQ-002 CLK1  in  1  system clock; all state updates on its rising edge.
REQ-003 RST_C  in  1  synchronous active-high reset.
REQ-004 LDD  in  1  load strobe; each cycle it is sampled high is one load request.
REQ-005 SEL  in  3  one-hot slot select from the destination selector; SEL[0]=S0, SEL[1]=S1, SEL[2]=S2.
REQ-006 D  in  4  data nibble for the selected slot.
REQ-007 RDY  in  1  downstream ready.
REQ-008 Q  out  12  assembled operand: slot k at Q[4k+3:4k].
REQ-009 VLD  out  1  Q holds a complete operand.
REQ-010 MASK  out  3  per-slot loaded flags of the frame being filled.
REQ-011 ERR  out  1  sticky flag: a load arrived with SEL not one-hot.
REQ-012 OVF  out  1  sticky flag: a load was dropped while FULL.

Function
REQ-013 States: FILL (collecting nibbles) and FULL (Q valid, waiting for RDY); reset state is FILL.
REQ-014 In FILL, a cycle with LDD=1 and SEL one-hot (slot k) SHALL write D into assembly slot k and set MASK[k] at the clock edge.
REQ-015 A write to a slot whose MASK bit is already set SHALL overwrite that slot's data; MASK is unchanged.
REQ-016 A load with SEL not one-hot (000, or two or more bits set) SHALL write nothing, leave MASK unchanged and set ERR.
REQ-017 The edge at which MASK would become 111 SHALL copy the assembly buffer, including the nibble written at that edge, into Q, set VLD, clear MASK and enter FULL.
REQ-018 Latency: VLD=1 in the cycle immediately after the clock edge that accepts the completing load.
REQ-019 Completion SHALL NOT depend on slot order; the selector's natural order is S2, S0, S1.
REQ-020 In FULL, Q and VLD SHALL hold while RDY=0.
REQ-021 In FULL, any LDD=1 cycle without a transfer SHALL be dropped and set OVF; no MASK or data change.
REQ-022 Transfer occurs on a cycle with VLD=1 and RDY=1; the next cycle has VLD=0 and state FILL.
REQ-023 On a cycle with both a transfer and a valid load, the load SHALL be accepted into the new frame, so the next MASK is the single bit of that slot.
REQ-024 A cycle with both a transfer and a non-one-hot load SHALL set ERR only.
REQ-025 RDY SHALL be ignored in FILL.
REQ-026 Q SHALL change only on entry to FULL.
REQ-027 ERR and OVF SHALL clear only on reset.

Reset
REQ-028 While RST_C=1 at an edge, the block SHALL set state FILL, Q=12'h000, VLD=0, MASK=000, ERR=0, OVF=0 and clear the assembly buffer.
REQ-029 Reset SHALL take priority over any simultaneous LDD or RDY activity.
REQ-030 Reset mid-frame or while FULL SHALL discard the partial or pending operand.

Structure
REQ-031 The shared package SHALL hold NIBBLE_W=4, SLOTS=3, OPERAND_W=12 and the state enum {FILL, FULL}.
REQ-032 One sub-module SHALL be used: onehot_chk (3-bit input; outputs a valid flag and a 2-bit index); all other logic is flat.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset, then loads of D=5 (SEL=100), D=A (SEL=001), D=3 (SEL=010) on consecutive cycles -> the cycle after the third load has VLD=1 and Q=12'h53A; MASK reads 100, 101, then 000.
- A complete frame with RDY=0 held for 4 cycles and LDD=1 pulsed -> Q and VLD unchanged, OVF=1; RDY=1 -> VLD=0 the next cycle.
- Transfer cycle concurrent with a load of D=7, SEL=010 -> next cycle VLD=0, MASK=010, slot 1 holds 7.
- Load with SEL=011, then a load with SEL=000 -> MASK unchanged, ERR=1 and still 1 after 10 idle cycles.
- Overwrite: slot 0 loaded with 1 then with 9, then slots 1=2 and 2=4 -> Q=12'h429.
- RST_C asserted with MASK=110 -> next cycle all outputs at reset values; a full new frame then assembles correctly.
